// File: rtl/pila_trig.sv
// pila_trig: trigger and capture sequencer for the pila capture buffer (cap_clk domain).
// Latency: capture_o/data_o are registered; a strobe appears one cycle after the cycle whose
//          probe data it carries. Backpressure: none, the buffer accepts every strobe.
//
// Ports:
//   cap_clk, rst        clock and synchronous active-high reset
//   arm_i, abort_i      host control; abort_i wins when both are high
//   trig_mask_i/value_i masked compare against the probe bus
//   trig_edge_i         0 = fire on match level, 1 = fire on rising edge of match
//   decim_i, depth_i    capture spacing (decim_i+1 cycles) and sample count (0 = maximum),
//                       both latched when the sequencer arms
//   data_i              probe bus
//   buf_clear_o         one-cycle clear pulse to the buffer at arm
//   capture_o, data_o   write strobe and aligned sample to the buffer
//   state_o             IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   triggered_o, done_o status flags

module pila_trig #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  cap_clk,
    input  logic                  rst,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic [WIDTH-1:0]      trig_mask_i,
    input  logic [WIDTH-1:0]      trig_value_i,
    input  logic                  trig_edge_i,
    input  logic [DIV_WIDTH-1:0]  decim_i,
    input  logic [ADDR_WIDTH-1:0] depth_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic                  buf_clear_o,
    output logic                  capture_o,
    output logic [WIDTH-1:0]      data_o,
    output logic [1:0]            state_o,
    output logic                  triggered_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_inc;
    logic [ADDR_WIDTH-1:0] target;
    logic [DIV_WIDTH-1:0]  div;
    logic [DIV_WIDTH-1:0]  decim;
    logic                  match;
    logic                  match_prev;
    logic                  fire;

    assign match   = ((data_i ^ trig_value_i) & trig_mask_i) == '0;
    // match_prev is forced high at arm, so edge mode needs a non-match seen after arming.
    assign fire    = trig_edge_i ? (match & ~match_prev) : match;
    assign cnt_inc = cnt + ADDR_WIDTH'(1);
    assign state_o = state;

    always_ff @(posedge cap_clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            buf_clear_o <= 1'b0;
            capture_o   <= 1'b0;
            data_o      <= '0;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
            cnt         <= '0;
            target      <= '0;
            div         <= '0;
            decim       <= '0;
            match_prev  <= 1'b1;
        end else begin
            // Probe data is pipelined unconditionally so it lines up with capture_o.
            data_o      <= data_i;
            match_prev  <= match;
            buf_clear_o <= 1'b0;

            if (abort_i && (state != ST_IDLE)) begin
                // Abort keeps buffer contents and the triggered flag; no clear pulse.
                state     <= ST_IDLE;
                capture_o <= 1'b0;
                done_o    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        capture_o <= 1'b0;
                        if (arm_i && !abort_i) begin
                            state       <= ST_ARMED;
                            buf_clear_o <= 1'b1;
                            cnt         <= '0;
                            triggered_o <= 1'b0;
                            done_o      <= 1'b0;
                            // depth 0 selects the largest run that cannot fill the buffer.
                            target      <= (depth_i == '0) ? '1 : depth_i;
                            decim       <= decim_i;
                            match_prev  <= 1'b1;
                        end
                    end

                    ST_ARMED: begin
                        if (fire) begin
                            // The triggering sample itself is the first capture.
                            capture_o   <= 1'b1;
                            triggered_o <= 1'b1;
                            cnt         <= ADDR_WIDTH'(1);
                            div         <= decim;
                            if (target == ADDR_WIDTH'(1)) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= ST_CAPTURE;
                            end
                        end else begin
                            capture_o <= 1'b0;
                        end
                    end

                    ST_CAPTURE: begin
                        if (div == '0) begin
                            capture_o <= 1'b1;
                            cnt       <= cnt_inc;
                            div       <= decim;
                            // Leave on the same edge that issues the final strobe.
                            if (cnt_inc == target) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end
                        end else begin
                            capture_o <= 1'b0;
                            div       <= div - DIV_WIDTH'(1);
                        end
                    end

                    default: begin
                        state     <= ST_IDLE;
                        capture_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pila_trig.sv
// Testbench for pila_trig: directed and randomized runs against a cycle-list model.
// The model predicts, per run, the cycle and data of every clear pulse and capture strobe.
// A monitor pops those predictions whenever the DUT asserts buf_clear_o or capture_o.

module tb_pila_trig;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MAXD = (1 << AW) - 1;

    logic          cap_clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [W-1:0]  trig_mask_i = '0;
    logic [W-1:0]  trig_value_i = '0;
    logic          trig_edge_i = 1'b0;
    logic [DW-1:0] decim_i = '0;
    logic [AW-1:0] depth_i = '0;
    logic [W-1:0]  data_i = '0;
    logic          buf_clear_o;
    logic          capture_o;
    logic [W-1:0]  data_o;
    logic [1:0]    state_o;
    logic          triggered_o;
    logic          done_o;

    pila_trig #(.WIDTH(W), .ADDR_WIDTH(AW), .DIV_WIDTH(DW)) dut (
        .cap_clk      (cap_clk),
        .rst          (rst),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .trig_mask_i  (trig_mask_i),
        .trig_value_i (trig_value_i),
        .trig_edge_i  (trig_edge_i),
        .decim_i      (decim_i),
        .depth_i      (depth_i),
        .data_i       (data_i),
        .buf_clear_o  (buf_clear_o),
        .capture_o    (capture_o),
        .data_o       (data_o),
        .state_o      (state_o),
        .triggered_o  (triggered_o),
        .done_o       (done_o)
    );

    always #5 cap_clk = ~cap_clk;

    int cyc = 0;
    always @(posedge cap_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [W-1:0] dat;
    } exp_t;

    exp_t     cap_q[$];
    int       clr_q[$];
    exp_t     got;
    int       got_clr;
    int       tests = 0;
    int       fails = 0;
    logic [W-1:0] seq [0:255];
    bit       exp_trig = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest prediction.
    always @(negedge cap_clk) begin
        if (capture_o) begin
            if (cap_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL capture_unexpected: strobe at cycle %0d data 0x%0h, none expected", cyc, data_o);
            end else begin
                got = cap_q.pop_front();
                chk("capture_cycle", cyc, got.cyc);
                chk("capture_data", data_o, got.dat);
            end
        end
        if (buf_clear_o) begin
            if (clr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL clear_unexpected: clear pulse at cycle %0d, none expected", cyc);
            end else begin
                got_clr = clr_q.pop_front();
                chk("clear_cycle", cyc, got_clr);
            end
        end
    end

    function automatic bit mt(input logic [W-1:0] d, input logic [W-1:0] m, input logic [W-1:0] v);
        return ((d ^ v) & m) == '0;
    endfunction

    // Random probe data with frequent matches; cycles 3/4 force a non-match then a match so
    // both trigger modes are guaranteed to fire.
    task automatic fill_seq(input logic [W-1:0] m, input logic [W-1:0] v);
        logic [W-1:0] d;
        for (int k = 0; k < 256; k++) begin
            d = W'($urandom);
            if ($urandom_range(0, 2) == 0) d = (d & ~m) | (v & m);
            seq[k] = d;
        end
        if (m != '0) begin
            seq[3] = v ^ (m & (~m + W'(1)));
            seq[4] = v;
        end
    endtask

    // kind: 0 = run to completion, 1 = abort in cycle kill_at, 2 = rst in cycle kill_at,
    //       3 = abort at a random cycle. Cycle 0 of the run is the arm cycle.
    task automatic run(input logic [W-1:0] m, input logic [W-1:0] v, input bit edg,
                       input int decim, input int depth, input int kind_in, input int kill_in,
                       input string tag);
        int   target, f, last_dec, len, start, d, kind, kill_at;
        bit   prev, fire;
        exp_t e;
        kind    = kind_in;
        kill_at = kill_in;
        target  = (depth == 0) ? MAXD : depth;
        f = -1;
        for (int k = 1; k < 200 && f < 0; k++) begin
            prev = (k == 1) ? 1'b1 : mt(seq[k-1], m, v);
            fire = edg ? (mt(seq[k], m, v) && !prev) : mt(seq[k], m, v);
            if (fire) f = k;
        end
        last_dec = f + (target - 1) * (decim + 1);
        if (kind == 3) begin
            kill_at = $urandom_range(1, last_dec + 2);
            kind = 1;
        end
        len = (kind == 0) ? last_dec + 3 : kill_at + 1;

        trig_mask_i  = m;
        trig_value_i = v;
        trig_edge_i  = edg;
        @(posedge cap_clk);
        #1;
        start = cyc;
        if (!(kind != 0 && kill_at == 0)) clr_q.push_back(start + 1);
        for (int i = 0; i < target; i++) begin
            d = f + i * (decim + 1);
            if (kind == 0 || d < kill_at) begin
                e.cyc = start + d + 1;
                e.dat = seq[d];
                cap_q.push_back(e);
            end
        end
        if (kind == 2) exp_trig = 1'b0;
        else if (!(kind != 0 && kill_at == 0)) exp_trig = (kind == 0) || (f < kill_at);

        for (int k = 0; k < len; k++) begin
            if (k > 0) begin
                @(posedge cap_clk);
                #1;
            end
            data_i  = seq[k];
            arm_i   = (k == 0);
            abort_i = (kind == 1 && k == kill_at);
            rst     = (kind == 2 && k == kill_at);
            // Configuration after the arm cycle must be ignored.
            depth_i = (k == 0) ? AW'(depth) : AW'($urandom);
            decim_i = (k == 0) ? DW'(decim) : DW'($urandom);
            @(negedge cap_clk);
            if (k == 1 && !(kind != 0 && kill_at == 0)) chk({tag, "_armed_state"}, state_o, 2'd1);
            if (k == f + 1 && (kind == 0 || f < kill_at)) begin
                chk({tag, "_fire_state"}, state_o, (target == 1) ? 2'd3 : 2'd2);
                chk({tag, "_fire_triggered"}, triggered_o, 1'b1);
            end
        end
        @(posedge cap_clk);
        #1;
        arm_i   = 1'b0;
        abort_i = 1'b0;
        rst     = 1'b0;
        @(negedge cap_clk);
        chk({tag, "_end_capture"}, capture_o, 1'b0);
        chk({tag, "_end_triggered"}, triggered_o, exp_trig);
        if (kind == 0) begin
            chk({tag, "_end_state"}, state_o, 2'd3);
            chk({tag, "_end_done"}, done_o, 1'b1);
        end else begin
            chk({tag, "_end_state"}, state_o, 2'd0);
            chk({tag, "_end_done"}, done_o, 1'b0);
        end
        if (kind == 2) begin
            chk({tag, "_rst_data"}, data_o, '0);
            chk({tag, "_rst_clear"}, buf_clear_o, 1'b0);
        end
        chk({tag, "_pending_captures"}, cap_q.size(), 0);
        chk({tag, "_pending_clears"}, clr_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] m, v;
        bit           edg;

        repeat (2) @(posedge cap_clk);
        @(negedge cap_clk);
        chk("reset_state", state_o, 2'd0);
        chk("reset_capture", capture_o, 1'b0);
        chk("reset_clear", buf_clear_o, 1'b0);
        chk("reset_triggered", triggered_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_data", data_o, '0);
        rst = 1'b0;
        repeat (2) @(posedge cap_clk);

        // Level trigger: 0x0041 misses, 0x1242 matches under mask 0x00FF.
        fill_seq(16'h00FF, 16'h0042);
        seq[1] = 16'h0041;
        seq[2] = 16'h1242;
        run(16'h00FF, 16'h0042, 1'b0, 0, 4, 0, 0, "level");

        // Re-arm from DONE with identical stimulus.
        run(16'h00FF, 16'h0042, 1'b0, 0, 4, 0, 0, "rearm");

        // Edge trigger: match held across arm must not fire; fires on the return to match.
        fill_seq(16'hFFFF, 16'h0005);
        for (int k = 0; k < 4; k++) seq[k] = 16'h0005;
        seq[4] = 16'h0000;
        seq[5] = 16'h0005;
        run(16'hFFFF, 16'h0005, 1'b1, 0, 2, 0, 0, "edge");

        // Decimation on a counter pattern.
        for (int k = 0; k < 256; k++) seq[k] = W'(100 + k);
        run(16'h0000, 16'h0000, 1'b0, 2, 3, 0, 0, "decim");

        // depth 0 means the maximum count.
        fill_seq(16'h0000, 16'h0000);
        run(16'h0000, 16'h0000, 1'b0, 0, 0, 0, 0, "depth0");

        // Single-sample run goes straight to DONE.
        fill_seq(16'h0000, 16'h0000);
        run(16'h0000, 16'h0000, 1'b0, 1, 1, 0, 0, "depth1");

        // Abort after two of eight strobes, then arm and abort together from IDLE.
        fill_seq(16'h0000, 16'h0000);
        run(16'h0000, 16'h0000, 1'b0, 0, 8, 1, 3, "abort");
        run(16'h0000, 16'h0000, 1'b0, 0, 8, 1, 0, "arm_abort");

        // Reset during capture.
        fill_seq(16'h0000, 16'h0000);
        run(16'h0000, 16'h0000, 1'b0, 0, 8, 2, 3, "rst_mid");

        for (int r = 0; r < 30; r++) begin
            m   = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            v   = W'($urandom);
            edg = (m != '0) && ($urandom_range(0, 1) == 1);
            fill_seq(m, v);
            run(m, v, edg, $urandom_range(0, 3), $urandom_range(0, MAXD),
                ($urandom_range(0, 3) == 0) ? 3 : 0, 0, "rand");
        end

        repeat (4) @(posedge cap_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/pila_trig.md
Name: pila_trig

Overview:
- Trigger and capture sequencer for the pila capture buffer, clocked in the cap_clk domain.
- Arms on host request and clears the buffer, then waits for a masked, level- or edge-qualified trigger on the probe bus.
- After triggering, it issues capture strobes with optional decimation until the programmed depth is reached.
- Its outputs drive pila directly: buf_clear_o is OR'd into pila rst, capture_o drives capture_i, and data_o drives data_i.

Parameters:
WIDTH, 16, probe/sample width; matches the pila WIDTH.
ADDR_WIDTH, 8, buffer address width; matches the pila ADDR_WIDTH.
DIV_WIDTH, 8, width of the decimation divider.

Ports:
cap_clk  in  1  capture clock.
rst  in  1  synchronous, active-high reset.
arm_i  in  1  arm request, level-sampled each cycle.
abort_i  in  1  abort request; has priority over arm_i.
trig_mask_i  in  WIDTH  trigger bit mask; 1 = bit participates.
trig_value_i  in  WIDTH  trigger compare value.
trig_edge_i  in  1  0 = level trigger, 1 = rising-edge-of-match trigger.
decim_i  in  DIV_WIDTH  captures occur every decim_i+1 cycles after the trigger.
depth_i  in  ADDR_WIDTH  samples to capture; 0 = maximum (2**ADDR_WIDTH-1).
data_i  in  WIDTH  probe bus.
buf_clear_o  out  1  one-cycle clear pulse to the buffer.
capture_o  out  1  write strobe to the buffer.
data_o  out  WIDTH  registered probe data, aligned with capture_o.
state_o  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
triggered_o  out  1  set once the trigger has fired.
done_o  out  1  high while in DONE.

Behaviour:
Reset:
- On rst: state IDLE; buf_clear_o, capture_o, triggered_o and done_o = 0; data_o = 0; counters = 0; match_prev = 1.

Trigger match:
- match = (((data_i ^ trig_value_i) & trig_mask_i) == 0), evaluated combinationally each cycle.
- match_prev <= match every cycle; it is forced to 1 on the arm cycle.
- Fire condition: level mode = match; edge mode = match & ~match_prev. Edge mode therefore requires at least one non-match after arming.
- mask = 0 in level mode fires on the first ARMED cycle.

Datapath:
- data_o <= data_i every cycle, unconditionally, so data_o during a capture_o cycle is data_i from the cycle the decision was made.

Configuration latching:
- At arm, depth_i latches into the target register: 0 maps to all-ones, otherwise depth_i.
- At arm, decim_i is latched.
- Inputs may change afterwards without effect.

IDLE / DONE:
- arm_i=1 (and abort_i=0) -> ARMED. On that edge buf_clear_o <= 1 for exactly one cycle; cnt <= 0; triggered_o <= 0; done_o <= 0.

ARMED:
- Fire -> CAPTURE. On the same edge capture_o <= 1 (trigger sample), triggered_o <= 1, cnt <= 1, div <= decim.
- If target == 1, go straight to DONE instead.
- arm_i is ignored.
- The earliest capture_o is 2 cycles after the arm cycle, so it never coincides with buf_clear_o.

CAPTURE:
- div decrements each cycle. When div == 0: capture_o <= 1, cnt <= cnt+1, div <= decim. Otherwise capture_o <= 0.
- When the strobe being issued makes cnt == target, the state moves to DONE on the same edge.
- capture_o is asserted exactly target times per run; with decim = 0 they are contiguous.

DONE:
- capture_o <= 0; done_o = 1; triggered_o is held.
- A re-arm is allowed.

abort_i:
- In any state other than IDLE: state <= IDLE; capture_o <= 0 next edge; no buf_clear_o.
- Samples already in the buffer are kept; triggered_o keeps its value.
- If abort_i and arm_i are high in the same cycle, abort_i wins.

rst mid-run:
- Immediate return to reset values. buf_clear_o is not pulsed, because the system rst already clears pila.

Counters:
- cnt is ADDR_WIDTH bits and never exceeds target ≤ 2**ADDR_WIDTH-1, so it cannot wrap.
- div is DIV_WIDTH bits.
- The buffer-full stop in pila is therefore never reached before DONE.

Test Plan:
1. Level trigger: mask=16'h00FF, value=16'h0042, depth=4, decim=0; arm, drive 0x0041 then 0x1242 -> buf_clear_o pulses the cycle after arm; capture_o high 4 consecutive cycles; first data_o=0x1242; state 1->2->3; done_o=1.
2. Edge trigger: mask=FFFF, value=0x0005, data_i held at 0x0005 before and after arm -> no fire; drop to 0x0000 then back to 0x0005 -> fires on the return; triggered_o=1.
3. Decimation: decim=2, depth=3, counter pattern on data_i -> capture_o on cycles T, T+3, T+6; data_o = n, n+3, n+6; then DONE.
4. depth=0 with ADDR_WIDTH=4: mask=0, arm -> 15 strobes; pila write_addr_o ends at 15; no 16th strobe.
5. Abort mid-capture after 2 of 8 strobes -> capture_o low next cycle; state=0; triggered_o=1; done_o=0. arm_i and abort_i in the same cycle -> stays IDLE, no clear pulse.
6. Re-arm from DONE -> buf_clear_o pulse, triggered_o/done_o cleared, second run identical to the first. rst asserted during CAPTURE -> all outputs 0, state IDLE.
